latency_port_arb: RTL
=====================

LATENCY_PORT_ARB -- requirements
Module: latency_port_arb

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 13, meaning the width of the RAM data word (encoded word plus flag bit).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning the RAM address width.
REQ-003 The block SHALL have parameter WR_LATENCY, default 1, range 1..8, meaning the RAM port write latency in cycles.
REQ-004 The block SHALL have parameter RD_LATENCY, default 1, range 1..8, meaning the RAM port read latency in cycles.
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clka  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req0_valid / i_req1_valid  in  1  requester 0/1 has a request.
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle.
- i_req0_we / i_req1_we  in  1  1=write, 0=read.
- i_req0_addr / i_req1_addr  in  ADDR_WIDTH  request address.
- i_req0_din / i_req1_din  in  WORD_WIDTH  write data.
- o_ram_en, o_ram_we  out  1  RAM port enable / write enable.
- o_ram_addr  out  ADDR_WIDTH  RAM port address.
- o_ram_din  out  WORD_WIDTH  RAM write data.
- i_ram_dout  in  WORD_WIDTH  RAM read data.
- o_rsp0_valid / o_rsp1_valid  out  1  read data for requester 0/1.
- o_rsp_data  out  WORD_WIDTH  read data, equal to i_ram_dout.
- o_busy  out  1  any read or write still in flight.

Function
REQ-006 A request SHALL be accepted only in a cycle where valid and ready are both 1; at most one ready SHALL be 1 per cycle.
REQ-007 Arbitration SHALL be round-robin: with both valid, the requester holding the priority pointer is granted; after any grant, the pointer SHALL move to the other requester; with one valid, that requester is granted regardless of the pointer.
REQ-008 ready SHALL be a combinational function of the valid inputs, the pointer and the hazard state; a requester with valid=0 SHALL see ready=0.
REQ-009 An accepted request SHALL drive o_ram_en=1, o_ram_we, o_ram_addr and o_ram_din on the next cycle for exactly one cycle; otherwise o_ram_en=0 and o_ram_we=0.
REQ-010 A read track shift register, RD_LATENCY+1 stages deep, SHALL carry a valid bit and a requester ID; the read accepted in cycle N SHALL assert exactly one o_rspX_valid in cycle N+1+RD_LATENCY.
REQ-011 A write track register, WR_LATENCY+1 stages deep, SHALL hold the address and valid bit of every write until it has been committed.
REQ-012 Back-to-back accepts every cycle SHALL be supported with no bubble; responses SHALL return in acceptance order.
REQ-013 o_busy SHALL be 1 while any read-track or write-track stage is valid.
REQ-014 Writes SHALL never stall, except through arbitration loss.

Reset
REQ-015 While rst=1 at a clka edge, the block SHALL clear all track stages, set the pointer to requester 0, and drive o_ram_en=0, o_ram_we=0, o_rsp0_valid=0, o_rsp1_valid=0 and o_busy=0 from the next cycle.
REQ-016 o_ram_addr, o_ram_din and o_rsp_data SHALL be don't-care during reset; both ready outputs SHALL be 0 while rst=1.
REQ-017 Reset asserted mid-operation SHALL discard in-flight reads, so that no o_rspX_valid is asserted for them after reset.

Configuration
REQ-018 Macro LATENCY_ARB_HAZARD_CHECK_EN, when defined, SHALL deassert ready for a read whose address matches any valid write-track address or a same-cycle grant-eligible write, until that write retires; the pointer SHALL still move per REQ-007, and the other requester MAY be granted instead.
REQ-019 Without LATENCY_ARB_HAZARD_CHECK_EN, reads SHALL never be stalled on address, and read-after-write ordering is the requester's responsibility.

Verification
REQ-020 Scenario: after reset, req0 read addr 3 only -> o_ram_en=1 with addr 3 at the next cycle; o_rsp0_valid at acceptance+1+RD_LATENCY; o_rsp1_valid stays 0.
REQ-021 Scenario: both requesters hold valid for 4 cycles -> grants alternate 0,1,0,1, starting with requester 0.
REQ-022 Scenario: RD_LATENCY=3, alternating reads 0,1,0,1 back-to-back -> rsp valids follow the order 0,1,0,1, each 4 cycles after its accept, with no bubbles.
REQ-023 Scenario: with the macro defined and WR_LATENCY=2, req0 writes 0x0A5 to addr 5, then req1 reads addr 5 the next cycle -> req1 is stalled until the write retires, then reads 0x0A5; without the macro, there is no stall.
REQ-024 Scenario: rst pulsed one cycle after a read accept with RD_LATENCY=4 -> no rsp valid appears afterwards, o_busy=0, and the pointer is back at requester 0.

Source files
------------

// File: rtl/latency_port_arb_if.sv
// Bundle of the two requester ports, the RAM port and the response port of latency_port_arb.
interface latency_port_arb_if #(
    parameter int unsigned WORD_WIDTH = 13,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  i_req0_valid;
    logic                  i_req1_valid;
    logic                  o_req0_ready;
    logic                  o_req1_ready;
    logic                  i_req0_we;
    logic                  i_req1_we;
    logic [ADDR_WIDTH-1:0] i_req0_addr;
    logic [ADDR_WIDTH-1:0] i_req1_addr;
    logic [WORD_WIDTH-1:0] i_req0_din;
    logic [WORD_WIDTH-1:0] i_req1_din;
    logic                  o_ram_en;
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [WORD_WIDTH-1:0] o_ram_din;
    logic [WORD_WIDTH-1:0] i_ram_dout;
    logic                  o_rsp0_valid;
    logic                  o_rsp1_valid;
    logic [WORD_WIDTH-1:0] o_rsp_data;
    logic                  o_busy;

    // Arbiter side
    modport slave (
        input  i_req0_valid, i_req1_valid, i_req0_we, i_req1_we,
        input  i_req0_addr, i_req1_addr, i_req0_din, i_req1_din, i_ram_dout,
        output o_req0_ready, o_req1_ready, o_ram_en, o_ram_we, o_ram_addr, o_ram_din,
        output o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy
    );

    // Requester / RAM side
    modport master (
        output i_req0_valid, i_req1_valid, i_req0_we, i_req1_we,
        output i_req0_addr, i_req1_addr, i_req0_din, i_req1_din, i_ram_dout,
        input  o_req0_ready, o_req1_ready, o_ram_en, o_ram_we, o_ram_addr, o_ram_din,
        input  o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy
    );
endinterface

// File: rtl/latency_port_arb.sv
// Two-requester round-robin arbiter in front of a single RAM port with fixed
// read/write latencies. Read responses are tracked by a valid/ID shift register.
// Optional macro LATENCY_ARB_HAZARD_CHECK_EN stalls reads that hit an
// in-flight (or same-cycle) write address until that write retires.
module latency_port_arb #(
    parameter int unsigned WORD_WIDTH = 13,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WR_LATENCY = 1,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic               clka,
    input logic               rst,
    latency_port_arb_if.slave bus
);
    localparam int unsigned RD_STAGES = RD_LATENCY + 1;
    localparam int unsigned WR_STAGES = WR_LATENCY + 1;
`ifdef LATENCY_ARB_HAZARD_CHECK_EN
    localparam bit HAZARD_EN = 1'b1;
`else
    localparam bit HAZARD_EN = 1'b0;
`endif

    logic                  ptr;
    logic [RD_STAGES-1:0]  rd_vld;
    logic [RD_STAGES-1:0]  rd_id;
    logic [WR_STAGES-1:0]  wr_vld;
    logic [ADDR_WIDTH-1:0] wr_addr [WR_STAGES];

    logic                  hit0, hit1, haz0, haz1;
    logic                  elig0, elig1, grant0, grant1, grant_any;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0] sel_din;

    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WORD_WIDTH-1:0] ram_din;

    // Read-after-write hazard detection against the write track and the other requester's write
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        for (int unsigned i = 0; i < WR_STAGES; i++) begin
            if (wr_vld[i] && (wr_addr[i] == bus.i_req0_addr)) hit0 = 1'b1;
            if (wr_vld[i] && (wr_addr[i] == bus.i_req1_addr)) hit1 = 1'b1;
        end
        haz0 = HAZARD_EN && !bus.i_req0_we &&
               (hit0 || (bus.i_req1_valid && bus.i_req1_we && (bus.i_req1_addr == bus.i_req0_addr)));
        haz1 = HAZARD_EN && !bus.i_req1_we &&
               (hit1 || (bus.i_req0_valid && bus.i_req0_we && (bus.i_req0_addr == bus.i_req1_addr)));
    end

    // Round-robin grant: pointer breaks ties, a lone eligible requester always wins
    always_comb begin
        elig0     = bus.i_req0_valid && !haz0;
        elig1     = bus.i_req1_valid && !haz1;
        grant0    = !rst && elig0 && (!elig1 || !ptr);
        grant1    = !rst && elig1 && (!elig0 || ptr);
        grant_any = grant0 || grant1;
        sel_we    = grant1 ? bus.i_req1_we   : bus.i_req0_we;
        sel_addr  = grant1 ? bus.i_req1_addr : bus.i_req0_addr;
        sel_din   = grant1 ? bus.i_req1_din  : bus.i_req0_din;
    end

    // Priority pointer moves to the requester that was not just granted
    always_ff @(posedge clka) begin
        if (rst)         ptr <= 1'b0;
        else if (grant0) ptr <= 1'b1;
        else if (grant1) ptr <= 1'b0;
    end

    // RAM port strobes: one-cycle pulse after each accept
    always_ff @(posedge clka) begin
        if (rst) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
        end else begin
            ram_en <= grant_any;
            ram_we <= grant_any && sel_we;
        end
    end

    // RAM address/data need no reset, they are qualified by ram_en
    always_ff @(posedge clka) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_din;
    end

    // Read and write track valid bits, cleared on reset to drop in-flight work
    always_ff @(posedge clka) begin
        if (rst) begin
            rd_vld <= '0;
            wr_vld <= '0;
        end else begin
            rd_vld <= {rd_vld[RD_STAGES-2:0], grant_any && !sel_we};
            wr_vld <= {wr_vld[WR_STAGES-2:0], grant_any && sel_we};
        end
    end

    // Track payloads: requester ID for reads, address for writes
    always_ff @(posedge clka) begin
        rd_id      <= {rd_id[RD_STAGES-2:0], grant1};
        wr_addr[0] <= sel_addr;
        for (int unsigned i = 1; i < WR_STAGES; i++) wr_addr[i] <= wr_addr[i-1];
    end

    assign bus.o_req0_ready = grant0;
    assign bus.o_req1_ready = grant1;
    assign bus.o_ram_en     = ram_en;
    assign bus.o_ram_we     = ram_we;
    assign bus.o_ram_addr   = ram_addr;
    assign bus.o_ram_din    = ram_din;
    assign bus.o_rsp0_valid = rd_vld[RD_STAGES-1] && !rd_id[RD_STAGES-1];
    assign bus.o_rsp1_valid = rd_vld[RD_STAGES-1] &&  rd_id[RD_STAGES-1];
    assign bus.o_rsp_data   = bus.i_ram_dout;
    assign bus.o_busy       = (|rd_vld) || (|wr_vld);
endmodule
